// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard unit for the 5-stage RV32 pipeline.
//   Forwarding selects for the EX-stage source operands, load-use bubble
//   insertion, mul/div pipeline freeze sequencing, taken-branch squash and
//   a saturating stall-cycle performance counter.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   id_rs, id_rs_used  ID-stage source addresses / read enables (port i at [i*RA_W+:RA_W])
//   ex_*               EX-stage instruction info (sources, valid, rd, load, mul/div)
//   mem_regwrite/rd    EX/MEM writeback info
//   wb_regwrite/rd     MEM/WB writeback info
//   branch_taken       EX resolved a taken branch/jump
//   perf_clr           synchronous clear of stall_cnt
//   fwd_sel            per port 2'b10 EX/MEM, 2'b01 MEM/WB, 2'b00 regfile (combinational)
//   stall_if/id/ex     hold PC / IF/ID / ID/EX (combinational hazard controls)
//   bubble_ex          load NOP into ID/EX next edge
//   flush_id           load NOP into IF/ID next edge
//   md_done            mul/div result valid in EX this cycle
//   stall_cnt          saturating count of cycles with stall_if=1 (registered)
module hazard_fwd_ctrl #(
    parameter int unsigned NUM_RS     = 2,
    parameter int unsigned RA_W       = 5,
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_RS*RA_W-1:0]   id_rs,
    input  logic [NUM_RS-1:0]        id_rs_used,
    input  logic [NUM_RS*RA_W-1:0]   ex_rs,
    input  logic                     ex_valid,
    input  logic [RA_W-1:0]          ex_rd,
    input  logic                     ex_memread,
    input  logic                     ex_is_md,
    input  logic                     mem_regwrite,
    input  logic [RA_W-1:0]          mem_rd,
    input  logic                     wb_regwrite,
    input  logic [RA_W-1:0]          wb_rd,
    input  logic                     branch_taken,
    input  logic                     perf_clr,
    output logic [NUM_RS*2-1:0]      fwd_sel,
    output logic                     stall_if,
    output logic                     stall_id,
    output logic                     stall_ex,
    output logic                     bubble_ex,
    output logic                     flush_id,
    output logic                     md_done,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Holds MD_LATENCY-1 for every MD_LATENCY >= 2.
    localparam int unsigned MD_CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);
    localparam logic [MD_CNT_W-1:0] MD_ONE  = MD_CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t           state;
    md_state_t           state_nxt;
    logic [MD_CNT_W-1:0] md_cnt;
    logic [MD_CNT_W-1:0] md_cnt_nxt;
    logic                md_stall;
    logic                md_last;
    logic                load_use;

    // Forwarding: EX/MEM beats MEM/WB; x0 is never forwarded.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < int'(NUM_RS); i++) begin
            if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs[i*RA_W +: RA_W])) begin
                fwd_sel[i*2 +: 2] = 2'b10;
            end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs[i*RA_W +: RA_W])) begin
                fwd_sel[i*2 +: 2] = 2'b01;
            end
        end
    end

    // Load-use: a load in EX whose rd is read by any active ID source port.
    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_RS); i++) begin
            if (id_rs_used[i] && (id_rs[i*RA_W +: RA_W] == ex_rd)) begin
                hit = 1'b1;
            end
        end
        load_use = ex_valid && ex_memread && (ex_rd != '0) && hit;
    end

    // Mul/div FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Mul/div next state plus prioritised hazard outputs.
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        md_stall   = 1'b0;
        md_last    = 1'b0;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        bubble_ex  = 1'b0;
        flush_id   = 1'b0;
        md_done    = 1'b0;

        case (state)
            IDLE: begin
                if (ex_valid && ex_is_md) begin
                    md_stall   = 1'b1;
                    state_nxt  = BUSY;
                    md_cnt_nxt = MD_LOAD;
                end
            end
            BUSY: begin
                if (md_cnt > MD_ONE) begin
                    md_stall   = 1'b1;
                    md_cnt_nxt = md_cnt - MD_ONE;
                end else begin
                    md_last    = 1'b1;
                    state_nxt  = IDLE;
                    md_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt  = IDLE;
                md_cnt_nxt = '0;
            end
        endcase

        // Outputs are gated by rstn so they drop the moment reset asserts.
        if (rstn) begin
            md_done = md_last;
            if (md_stall) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
            end else if (branch_taken) begin
                // PC must take the redirect, so no stall even if load-use fires.
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    // Stall-cycle counter: clear beats increment, saturates at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
        end else if (stall_if && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed self-checking bench for hazard_fwd_ctrl (default parameters).
module tb_hazard_fwd_ctrl;

    localparam int unsigned NUM_RS = 2;
    localparam int unsigned RA_W   = 5;
    localparam int unsigned CNT_W  = 16;

    // Flag vector order: {stall_if, stall_id, stall_ex, bubble_ex, flush_id, md_done}
    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_LU   = 6'b110100;
    localparam logic [5:0] F_MD   = 6'b111000;
    localparam logic [5:0] F_DONE = 6'b000001;
    localparam logic [5:0] F_BR   = 6'b000110;

    logic                   clk;
    logic                   rstn;
    logic [NUM_RS*RA_W-1:0] id_rs;
    logic [NUM_RS-1:0]      id_rs_used;
    logic [NUM_RS*RA_W-1:0] ex_rs;
    logic                   ex_valid;
    logic [RA_W-1:0]        ex_rd;
    logic                   ex_memread;
    logic                   ex_is_md;
    logic                   mem_regwrite;
    logic [RA_W-1:0]        mem_rd;
    logic                   wb_regwrite;
    logic [RA_W-1:0]        wb_rd;
    logic                   branch_taken;
    logic                   perf_clr;
    logic [NUM_RS*2-1:0]    fwd_sel;
    logic                   stall_if;
    logic                   stall_id;
    logic                   stall_ex;
    logic                   bubble_ex;
    logic                   flush_id;
    logic                   md_done;
    logic [CNT_W-1:0]       stall_cnt;

    hazard_fwd_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .ex_rs        (ex_rs),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .ex_is_md     (ex_is_md),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .branch_taken (branch_taken),
        .perf_clr     (perf_clr),
        .fwd_sel      (fwd_sel),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .stall_ex     (stall_ex),
        .bubble_ex    (bubble_ex),
        .flush_id     (flush_id),
        .md_done      (md_done),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [25:0] val;
    } exp_t;

    exp_t             sb[$];
    int               n_total = 0;
    int               n_pass  = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             prev_sif = 1'b0;
    logic             prev_clr = 1'b0;

    task automatic clear_inputs();
        id_rs        = '0;
        id_rs_used   = '0;
        ex_rs        = '0;
        ex_valid     = 1'b0;
        ex_rd        = '0;
        ex_memread   = 1'b0;
        ex_is_md     = 1'b0;
        mem_regwrite = 1'b0;
        mem_rd       = '0;
        wb_regwrite  = 1'b0;
        wb_rd        = '0;
        branch_taken = 1'b0;
        perf_clr     = 1'b0;
    endtask

    // Advance one edge and update the counter model from last cycle's expectation.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (prev_clr) begin
            exp_cnt = '0;
        end else if (prev_sif && (exp_cnt != '1)) begin
            exp_cnt = exp_cnt + 16'd1;
        end
    endtask

    // Push expected outputs, let comb logic settle, pop and compare.
    task automatic chk(input string tag, input logic [3:0] f, input logic [5:0] fl);
        exp_t        e;
        logic [25:0] obs;
        e.tag = tag;
        e.val = {f, fl, exp_cnt};
        sb.push_back(e);
        #2;
        e   = sb.pop_front();
        obs = {fwd_sel, stall_if, stall_id, stall_ex, bubble_ex, flush_id, md_done, stall_cnt};
        n_total++;
        assert (obs === e.val) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
        prev_sif = fl[5];
        prev_clr = perf_clr;
    endtask

    task automatic load_use_inputs();
        ex_valid   = 1'b1;
        ex_memread = 1'b1;
        ex_rd      = 5'd6;
        id_rs      = {5'd6, 5'd2};
        id_rs_used = 2'b10;
    endtask

    task automatic run_md(input int n_ops);
        for (int op = 0; op < n_ops; op++) begin
            for (int k = 0; k < 3; k++) begin
                next_cycle();
                ex_valid = 1'b1;
                ex_is_md = 1'b1;
                chk("md_stall", 4'b0000, F_MD);
            end
            next_cycle();
            chk("md_done", 4'b0000, F_DONE);
        end
        next_cycle();
        clear_inputs();
        chk("md_idle", 4'b0000, F_NONE);
    endtask

    initial begin
        clear_inputs();
        rstn = 1'b0;
        // In reset: load-use present but outputs forced low; fwd_sel still live.
        load_use_inputs();
        ex_rs        = {5'd0, 5'd5};
        mem_regwrite = 1'b1;
        mem_rd       = 5'd5;
        @(posedge clk);
        #1;
        chk("reset_state", 4'b0010, F_NONE);
        clear_inputs();
        #1;
        rstn = 1'b1;

        // Forwarding patterns.
        next_cycle();
        ex_rs = {5'd5, 5'd5}; mem_regwrite = 1'b1; mem_rd = 5'd5; wb_regwrite = 1'b1; wb_rd = 5'd5;
        chk("fwd_exmem_wins", 4'b1010, F_NONE);
        next_cycle();
        ex_rs = {5'd3, 5'd5}; mem_rd = 5'd3;
        chk("fwd_mixed", 4'b1001, F_NONE);
        next_cycle();
        ex_rs = {5'd5, 5'd5}; mem_regwrite = 1'b0; mem_rd = 5'd5;
        chk("fwd_memwb_only", 4'b0101, F_NONE);
        next_cycle();
        ex_rs = '0; mem_regwrite = 1'b1; mem_rd = '0; wb_rd = '0;
        chk("fwd_x0", 4'b0000, F_NONE);
        next_cycle();
        ex_rs = {5'd5, 5'd5}; mem_regwrite = 1'b0; wb_regwrite = 1'b0; mem_rd = 5'd5; wb_rd = 5'd5;
        chk("fwd_no_write", 4'b0000, F_NONE);

        // Load-use: one bubble, then dependent op forwards from MEM/WB.
        next_cycle();
        clear_inputs();
        load_use_inputs();
        chk("lu_stall", 4'b0000, F_LU);
        next_cycle();
        ex_valid = 1'b0; ex_memread = 1'b0; ex_rd = '0;
        mem_regwrite = 1'b1; mem_rd = 5'd6;
        chk("lu_bubble_cycle", 4'b0000, F_NONE);
        next_cycle();
        clear_inputs();
        ex_valid = 1'b1; ex_rs = {5'd6, 5'd0}; wb_regwrite = 1'b1; wb_rd = 5'd6;
        chk("lu_dep_fwd", 4'b0100, F_NONE);
        next_cycle();
        clear_inputs();
        load_use_inputs();
        id_rs_used = 2'b01;
        chk("lu_port_unused", 4'b0000, F_NONE);
        next_cycle();
        ex_rd = '0; id_rs = '0; id_rs_used = 2'b11;
        chk("lu_rd_x0", 4'b0000, F_NONE);
        next_cycle();
        clear_inputs();
        chk("idle_after_lu", 4'b0000, F_NONE);

        // Two back-to-back mul/div ops.
        run_md(2);

        // Branch alone, then branch overriding load-use.
        next_cycle();
        branch_taken = 1'b1;
        chk("branch_only", 4'b0000, F_BR);
        next_cycle();
        load_use_inputs();
        chk("branch_over_lu", 4'b0000, F_BR);
        next_cycle();
        clear_inputs();
        chk("cnt_after_branch", 4'b0000, F_NONE);

        // Asynchronous reset in BUSY with cnt=2.
        next_cycle();
        ex_valid = 1'b1; ex_is_md = 1'b1;
        chk("rb_start", 4'b0000, F_MD);
        next_cycle();
        chk("rb_busy3", 4'b0000, F_MD);
        next_cycle();
        chk("rb_busy2", 4'b0000, F_MD);
        rstn    = 1'b0;
        exp_cnt = '0;
        chk("rb_async_drop", 4'b0000, F_NONE);
        @(posedge clk);
        #1;
        clear_inputs();
        rstn = 1'b1;
        chk("rb_released", 4'b0000, F_NONE);
        run_md(1);

        // Saturation and clear.
        next_cycle();
        load_use_inputs();
        chk("sat_start", 4'b0000, F_LU);
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            next_cycle();
        end
        chk("sat_hold", 4'b0000, F_LU);
        next_cycle();
        perf_clr = 1'b1;
        chk("clr_pending", 4'b0000, F_LU);
        next_cycle();
        perf_clr = 1'b0;
        chk("clr_done", 4'b0000, F_LU);
        next_cycle();
        chk("inc_after_clr", 4'b0000, F_LU);
        next_cycle();
        clear_inputs();
        chk("final_idle", 4'b0000, F_NONE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
